// File: rtl/video_system_sw_debounce.sv
// Switch debouncer: synchronises a raw board switch and only accepts a new level
// after it has held steady for DEBOUNCE_CYCLES+1 clocks, with one-clock edge strobes.
module video_system_sw_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_raw,
  output logic sw_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StStableLo,
    StWaitHi,
    StStableHi,
    StWaitLo
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  state_e                 state_q;
  logic [CntW-1:0]        cnt_q;
  logic                   sw_out_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw_raw};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // busy_q is loaded with the decode of the next state so it lines up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StStableLo;
      cnt_q    <= '0;
      sw_out_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      unique case (state_q)
        StStableLo: begin
          cnt_q <= '0;
          if (sync) begin
            state_q <= StWaitHi;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        StWaitHi: begin
          if (!sync) begin
            state_q <= StStableLo;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CntLast) begin
            state_q  <= StStableHi;
            cnt_q    <= '0;
            sw_out_q <= 1'b1;
            rise_q   <= 1'b1;
            busy_q   <= 1'b0;
          end else begin
            cnt_q  <= cnt_q + CntW'(1);
            busy_q <= 1'b1;
          end
        end
        StStableHi: begin
          cnt_q <= '0;
          if (!sync) begin
            state_q <= StWaitLo;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        StWaitLo: begin
          if (sync) begin
            state_q <= StStableHi;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CntLast) begin
            state_q  <= StStableLo;
            cnt_q    <= '0;
            sw_out_q <= 1'b0;
            fall_q   <= 1'b1;
            busy_q   <= 1'b0;
          end else begin
            cnt_q  <= cnt_q + CntW'(1);
            busy_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= StStableLo;
          cnt_q    <= '0;
          sw_out_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign sw_out     = sw_out_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign busy       = busy_q;

endmodule
